// File: rtl/xor18_rr_arbiter.sv
// Round-robin shared XOR unit: NREQ requesters compete for one WIDTH-bit XOR datapath,
// and the result is returned through a registered valid/ready response tagged with the winner's index.
module xor18_rr_arbiter #(
    parameter int WIDTH = 18,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [IDW-1:0]        rsp_id
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_reg;
    logic [IDW-1:0]       rr_ptr_reg;
    logic                 rsp_valid_reg;
    logic [WIDTH-1:0]     rsp_result_reg;
    logic [IDW-1:0]       rsp_id_reg;

    logic [IDW-1:0]       cand_idx [NREQ];
    logic [WIDTH-1:0]     xor_arr  [NREQ];
    logic                 grant_found;
    logic [IDW-1:0]       grant_idx;
    logic                 can_accept;
    logic                 accept;
    logic [IDW-1:0]       rr_ptr_next;

    // cand_idx[k] is the k-th requester visited when searching from rr_ptr with wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] idx_sum;
            assign idx_sum       = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
            assign cand_idx[gi]  = (idx_sum >= (IDW+1)'(NREQ)) ? IDW'(idx_sum - (IDW+1)'(NREQ))
                                                               : IDW'(idx_sum);
            assign xor_arr[gi]   = req_a[gi*WIDTH +: WIDTH] ^ req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Walk the search order from the far end so the nearest asserted requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign can_accept  = (state_reg == IDLE) || rsp_ready;
    assign accept      = rst_n && can_accept && grant_found;
    assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_id_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg      <= HOLD;
                        rsp_valid_reg  <= 1'b1;
                        rsp_result_reg <= xor_arr[grant_idx];
                        rsp_id_reg     <= grant_idx;
                        rr_ptr_reg     <= rr_ptr_next;
                    end
                end
                HOLD: begin
                    // Draining and refilling in the same cycle keeps one result per cycle.
                    if (accept) begin
                        rsp_result_reg <= xor_arr[grant_idx];
                        rsp_id_reg     <= grant_idx;
                        rr_ptr_reg     <= rr_ptr_next;
                    end else if (rsp_ready) begin
                        state_reg      <= IDLE;
                        rsp_valid_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_id     = rsp_id_reg;

endmodule

// File: tb/tb_xor18_rr_arbiter.sv
// Directed bench for xor18_rr_arbiter: reset, single op, round robin, wrap/skip,
// backpressure, operand boundaries and random operands against hand/locally computed results.
module tb_xor18_rr_arbiter;

    localparam int WIDTH = 18;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_result;
    logic [IDW-1:0]        rsp_id;

    int n_compared;
    int n_mismatched;

    xor18_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic load_rr_ops();
        for (int i = 0; i < NREQ; i++)
            set_ops(i, 18'h00F00 | WIDTH'(i), 18'h0F0F0);
    endtask

    initial begin
        int exp_g;
        int wrap_seq [3];
        logic [WIDTH-1:0] wrap_res [2];
        logic [WIDTH-1:0] ra, rb;
        int ridx;

        n_compared   = 0;
        n_mismatched = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        wrap_seq[0] = 0; wrap_seq[1] = 1; wrap_seq[2] = 0;
        wrap_res[0] = 18'h10001;
        wrap_res[1] = 18'h20022;

        // Held in reset: nothing granted even with every requester asking.
        repeat (3) tick();
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_result", 32'(rsp_result), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        req_valid = '0;
        rst_n = 1'b1;

        // Round robin with all requesters asserted; results are 0FFF0 | id.
        tick();
        load_rr_ops();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_g = k % NREQ;
            chk("rr_req_ready", 32'(req_ready), 32'(1 << exp_g));
            tick();
            chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(exp_g));
            chk("rr_rsp_result", 32'(rsp_result), 32'h0FFF0 | 32'(exp_g));
        end

        // Single op on requester 2 (pointer back at 0).
        req_valid = 4'b0100;
        set_ops(2, 18'h3FFFF, 18'h15555);
        #1;
        chk("single_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_result", 32'(rsp_result), 32'h2AAAA);
        chk("single_rsp_id", 32'(rsp_id), 32'h2);
        tick();
        chk("single_drain_idle", 32'(rsp_valid), 32'h0);

        // Wrap/skip: pointer at 3, requesters 0 and 1 only.
        set_ops(0, 18'h00001, 18'h10000);
        set_ops(1, 18'h00022, 18'h20000);
        req_valid = 4'b0011;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_g = wrap_seq[k];
            chk("wrap_req_ready", 32'(req_ready), 32'(1 << exp_g));
            tick();
            chk("wrap_rsp_id", 32'(rsp_id), 32'(exp_g));
            chk("wrap_rsp_result", 32'(rsp_result), 32'(wrap_res[exp_g]));
        end
        req_valid = '0;
        tick();
        chk("wrap_drain_idle", 32'(rsp_valid), 32'h0);

        // Backpressure: IDLE accepts requester 1 (pointer 1), then HOLD stalls.
        load_rr_ops();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'h2);
        tick();
        repeat (5) begin
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_id", 32'(rsp_id), 32'h1);
            chk("bp_rsp_result", 32'(rsp_result), 32'h0FFF1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h4);
        tick();
        chk("bp_next_valid", 32'(rsp_valid), 32'h1);
        chk("bp_next_id", 32'(rsp_id), 32'h2);
        chk("bp_next_result", 32'(rsp_result), 32'h0FFF2);

        // Boundaries: a==b gives zero; 0 ^ all-ones gives all-ones.
        req_valid = 4'b0001;
        set_ops(0, 18'h2ABCD, 18'h2ABCD);
        #1;
        chk("bnd_eq_ready", 32'(req_ready), 32'h1);
        tick();
        chk("bnd_eq_result", 32'(rsp_result), 32'h00000);
        chk("bnd_eq_id", 32'(rsp_id), 32'h0);
        req_valid = 4'b1000;
        set_ops(3, 18'h00000, 18'h3FFFF);
        #1;
        chk("bnd_ones_ready", 32'(req_ready), 32'h8);
        tick();
        chk("bnd_ones_result", 32'(rsp_result), 32'h3FFFF);
        chk("bnd_ones_id", 32'(rsp_id), 32'h3);

        // Random operands, one requester at a time, consumer always ready.
        for (int n = 0; n < 12; n++) begin
            ridx = int'($urandom_range(0, NREQ - 1));
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            set_ops(ridx, ra, rb);
            req_valid = 4'(1 << ridx);
            #1;
            chk("rnd_req_ready", 32'(req_ready), 32'(1 << ridx));
            tick();
            chk("rnd_rsp_result", 32'(rsp_result), 32'(ra ^ rb));
            chk("rnd_rsp_id", 32'(rsp_id), 32'(ridx));
        end

        // Reset in the middle of HOLD discards the held result; requester 0 favoured after.
        load_rr_ops();
        req_valid = 4'b0010;
        #1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("mid_hold_id", 32'(rsp_id), 32'h1);
        chk("mid_hold_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_result", 32'(rsp_result), 32'h0);
        chk("mid_rst_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        chk("post_rst_id", 32'(rsp_id), 32'h0);
        chk("post_rst_result", 32'(rsp_result), 32'h0FFF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
